hist_readout: RTL and testbench
===============================

Name: hist_readout

Overview:
- Downstream consumer of the histogram accumulator.
- After a measurement window closes (finish), waits for the accumulator pipeline to drain. It then sweeps every bin index through the accumulator's get_summary/index/summary read port.
- Streams each bin out on a valid/ready interface and produces frame statistics: total count, peak bin, non-zero bin count.
- Feeds the host-side result FIFO/register bank.

Parameters:
- DSIZE, 8, bin index width; NBINS = 2**DSIZE; legal range 1..10 (accumulator RAM address is 10 bits).
- RAM_RD_LAT, 1, cycles from index/get_summary valid to summary valid.
- SETTLE_CYC, 12, cycles to wait after finish before the first read (covers accumulator drain and write pipeline).
- SKIP_ZERO, 0, 1 = bins with count 0 are not presented on the stream (they are still scanned).

Ports:
- clock, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, new window begins; aborts any scan.
- finish, in, 1, window closed; triggers a scan.
- get_summary, out, 1, owns the accumulator read port while high.
- index, out, DSIZE, bin address to the accumulator.
- summary, in, 32, bin count returned by the accumulator.
- bin_idx, out, DSIZE, presented bin index.
- bin_cnt, out, 32, presented bin count.
- bin_vld, out, 1, stream valid.
- bin_rdy, in, 1, stream ready.
- bin_last, out, 1, marks the final bin of the frame.
- busy, out, 1, high from finish until done.
- done, out, 1, one-cycle pulse when the scan completes.
- total, out, 32+DSIZE, sum of all bins.
- max_cnt, out, 32, largest bin count.
- max_idx, out, DSIZE, index of the largest bin.
- nz_bins, out, DSIZE+1, number of non-zero bins.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- FSM states and transitions:
  - IDLE: finish -> SETTLE; clear total, max_cnt, max_idx, nz_bins; load settle counter with SETTLE_CYC-1.
  - SETTLE: count down; at 0 -> ISSUE with index=0.
  - ISSUE: drive get_summary=1 and index; load wait counter with RAM_RD_LAT -> WAIT.
  - WAIT: at counter 0, capture summary into bin_cnt and index into bin_idx; update statistics.
    - If presentation is required -> PRESENT.
    - Else, if index is the last bin -> DONE; otherwise increment index -> ISSUE.
  - PRESENT: bin_vld=1; data and bin_last are held stable until bin_vld && bin_rdy. On that handshake: if last -> DONE, else increment index -> ISSUE.
  - DONE: done=1 for one cycle -> IDLE.
- get_summary is held high continuously from the ISSUE of bin 0 until DONE, so the accumulator never switches the read address mid-scan.
- index only changes on transition into ISSUE.
- busy is high in SETTLE, ISSUE, WAIT, PRESENT and DONE.
- Throughput: one bin per RAM_RD_LAT+2 cycles with bin_rdy held high.
- Statistics update on every scanned bin, including skipped ones:
  - total += summary (full width, no saturation possible).
  - summary > max_cnt -> replace max_cnt and max_idx; on a tie the lowest index wins.
  - nz_bins increments when summary != 0.
- Statistics remain stable after DONE until the next finish.
- bin_last is asserted with the highest presented bin:
  - SKIP_ZERO=0: bin NBINS-1.
  - SKIP_ZERO=1: decided by look-ahead is not required. A zero-count last bin instead causes a final presentation of bin NBINS-1 with its count (0) and bin_last=1, so the frame is always terminated.
- Index wrap: index never wraps. The last-bin compare uses index == NBINS-1.
- start in any state -> IDLE next cycle: bin_vld=0, get_summary=0, busy=0, no done pulse; statistics retained.
- finish while busy: ignored.
- finish and start in the same cycle: start wins.
- Async reset mid-scan: immediate return to reset values.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SETTLE, ISSUE, WAIT, PRESENT, DONE).
  - Summary width constant SUM_W=32.
  - Function deriving NBINS and the total width from DSIZE.
- One natural sub-module, hist_stat_acc: the total/max/nz accumulator with clear and update enable. It is reusable for other statistics readouts.

Test Plan:
- DSIZE=4, bins 3=5 and 9=2 (others 0), SKIP_ZERO=0, bin_rdy=1 -> 16 beats; idx 3 cnt 5, idx 9 cnt 2, bin_last on idx 15; total=7, max_cnt=5, max_idx=3, nz_bins=2; done after 12+16*3 cycles.
- Same data, SKIP_ZERO=1 -> beats (3,5), (9,2), then (15,0,last); statistics identical.
- Tie: bins 2=8 and 7=8 -> max_idx=2, max_cnt=8.
- bin_rdy toggled 1-of-3 cycles -> bin_idx/bin_cnt/bin_last stable while bin_vld && !bin_rdy; no bins lost or duplicated.
- start asserted during PRESENT of bin 5 -> next cycle bin_vld=0, get_summary=0, busy=0; no done pulse; a subsequent finish rescans from index 0.
- All 16 bins = 32'hFFFF_FFFF -> total=36'hF_FFFF_FFF0, nz_bins=16, max_idx=0.

Source files
------------

// File: rtl/hist_readout_pkg.sv
// Shared definitions for the histogram readout: state encoding, widths, sizing helpers.
package hist_readout_pkg;

   localparam int unsigned SUM_W = 32;
   localparam int unsigned ST_W  = 3;

   localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [ST_W-1:0] ST_SETTLE  = 3'd1;
   localparam logic [ST_W-1:0] ST_ISSUE   = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT    = 3'd3;
   localparam logic [ST_W-1:0] ST_PRESENT = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

   // Number of histogram bins addressed by a dsize-bit index.
   function automatic int unsigned nbins_f(input int unsigned dsize);
      return 32'd1 << dsize;
   endfunction

   // Width of the frame total: a full bin count times the number of bins.
   function automatic int unsigned total_w_f(input int unsigned dsize);
      return SUM_W + dsize;
   endfunction

   // Bits needed for a down-counter holding 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w_f(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/hist_stat_acc.sv
// Running frame statistics: sum of values, largest value with its index, non-zero count.
module hist_stat_acc
   import hist_readout_pkg::*;
#(
   parameter int unsigned IDX_W = 8,
   parameter int unsigned VAL_W = SUM_W
)(
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   update,
   input  logic [IDX_W-1:0]       idx,
   input  logic [VAL_W-1:0]       val,
   output logic [IDX_W+VAL_W-1:0] total,
   output logic [VAL_W-1:0]       max_cnt,
   output logic [IDX_W-1:0]       max_idx,
   output logic [IDX_W:0]         nz_cnt
);

   localparam int unsigned TOT_W = IDX_W + VAL_W;
   localparam int unsigned NZ_W  = IDX_W + 1;

   // Clear at frame start, fold in one value per update; strict compare keeps the first maximum.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         total   <= '0;
         max_cnt <= '0;
         max_idx <= '0;
         nz_cnt  <= '0;
      end else if (clear) begin
         total   <= '0;
         max_cnt <= '0;
         max_idx <= '0;
         nz_cnt  <= '0;
      end else if (update) begin
         total <= total + TOT_W'(val);
         if (val > max_cnt) begin
            max_cnt <= val;
            max_idx <= idx;
         end
         if (val != '0) begin
            nz_cnt <= nz_cnt + NZ_W'(1);
         end
      end
   end

endmodule

// File: rtl/hist_readout.sv
// Post-window histogram readout: waits for the accumulator to drain, sweeps every bin
// through its read port, streams bins on valid/ready and keeps frame statistics.
module hist_readout
   import hist_readout_pkg::*;
#(
   parameter int unsigned DSIZE      = 8,
   parameter int unsigned RAM_RD_LAT = 1,
   parameter int unsigned SETTLE_CYC = 12,
   parameter int unsigned SKIP_ZERO  = 0
)(
   input  logic                          clock,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          finish,
   output logic                          get_summary,
   output logic [DSIZE-1:0]              index,
   input  logic [SUM_W-1:0]              summary,
   output logic [DSIZE-1:0]              bin_idx,
   output logic [SUM_W-1:0]              bin_cnt,
   output logic                          bin_vld,
   input  logic                          bin_rdy,
   output logic                          bin_last,
   output logic                          busy,
   output logic                          done,
   output logic [total_w_f(DSIZE)-1:0]   total,
   output logic [SUM_W-1:0]              max_cnt,
   output logic [DSIZE-1:0]              max_idx,
   output logic [DSIZE:0]                nz_bins
);

   localparam int unsigned    NBINS    = nbins_f(DSIZE);
   localparam int unsigned    SET_W    = cnt_w_f(SETTLE_CYC);
   localparam int unsigned    LAT_W    = cnt_w_f(RAM_RD_LAT);
   localparam logic [DSIZE-1:0] LAST_IDX = DSIZE'(NBINS - 1);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nxt;
   logic [SET_W-1:0] settle_cnt;
   logic [LAT_W-1:0] wait_cnt;

   logic last_c;
   logic capture_c;
   logic present_c;
   logic clear_c;
   logic update_c;

   // The read latency is counted from the ISSUE cycle, so WAIT spans RAM_RD_LAT cycles
   // and the data is sampled on the last of them.
   assign last_c    = (index == LAST_IDX);
   assign capture_c = (state == ST_WAIT) && (wait_cnt == '0);
   assign present_c = (SKIP_ZERO == 0) || (summary != '0) || last_c;
   assign clear_c   = (state == ST_IDLE) && (state_nxt == ST_SETTLE);
   assign update_c  = capture_c && !start;

   // State register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start overrides everything and returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (finish) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
               state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (capture_c) begin
                  if (present_c)   state_nxt = ST_PRESENT;
                  else if (last_c) state_nxt = ST_DONE;
                  else             state_nxt = ST_ISSUE;
               end
            end
            ST_PRESENT: begin
               if (bin_rdy) begin
                  if (bin_last) state_nxt = ST_DONE;
                  else          state_nxt = ST_ISSUE;
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Settle and read-latency down-counters.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         wait_cnt   <= '0;
      end else begin
         if (clear_c) begin
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
         end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
         end

         if ((state == ST_ISSUE) && (state_nxt == ST_WAIT)) begin
            wait_cnt <= LAT_W'(RAM_RD_LAT - 1);
         end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - LAT_W'(1);
         end
      end
   end

   // Registered control outputs, derived from the state being entered.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         get_summary <= 1'b0;
         bin_vld     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         get_summary <= (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT) ||
                        (state_nxt == ST_PRESENT);
         bin_vld     <= (state_nxt == ST_PRESENT);
         busy        <= (state_nxt != ST_IDLE);
         done        <= (state_nxt == ST_DONE);
      end
   end

   // Read address: restart at bin 0 after settling, step by one between bins, never wrap.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         index <= '0;
      end else if (state_nxt == ST_ISSUE) begin
         if (state == ST_SETTLE) index <= '0;
         else                    index <= index + DSIZE'(1);
      end
   end

   // Capture the returned bin; held stable through PRESENT until the handshake.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         bin_idx  <= '0;
         bin_cnt  <= '0;
         bin_last <= 1'b0;
      end else if (capture_c) begin
         bin_idx  <= index;
         bin_cnt  <= summary;
         bin_last <= last_c;
      end
   end

   // Frame statistics over every scanned bin, skipped or presented.
   hist_stat_acc #(
      .IDX_W (DSIZE),
      .VAL_W (SUM_W)
   ) u_stat (
      .clock   (clock),
      .rst_n   (rst_n),
      .clear   (clear_c),
      .update  (update_c),
      .idx     (index),
      .val     (summary),
      .total   (total),
      .max_cnt (max_cnt),
      .max_idx (max_idx),
      .nz_cnt  (nz_bins)
   );

endmodule

// File: tb/tb_hist_readout.sv
// Scoreboard bench for hist_readout: two instances (SKIP_ZERO=0 and 1) read a shared bin memory.
module tb_hist_readout;

   localparam int unsigned DS = 4;
   localparam int unsigned NB = 16;

   typedef struct packed {
      logic [DS-1:0] idx;
      logic [31:0]   cnt;
      logic          last;
   } beat_t;

   logic clock;
   logic rst_n;
   logic start;
   logic finish;
   logic bin_rdy;

   logic          gs0, gs1;
   logic [DS-1:0] ix0, ix1;
   logic [31:0]   sum0, sum1;
   logic [DS-1:0] bidx0, bidx1;
   logic [31:0]   bcnt0, bcnt1;
   logic          bvld0, bvld1;
   logic          blast0, blast1;
   logic          bsy0, bsy1;
   logic          dn0, dn1;
   logic [35:0]   tot0, tot1;
   logic [31:0]   mx0, mx1;
   logic [DS-1:0] mi0, mi1;
   logic [DS:0]   nz0, nz1;

   logic [31:0] mem [NB];
   beat_t q0[$];
   beat_t q1[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fin_cyc = 0;
   int done_cnt [2];
   int done_cyc [2];
   logic prev_dn [2];
   logic held [2];
   beat_t held_b [2];

   int   rdy_mode  = 0;
   int   rdy_ph    = 0;
   logic rdy_base  = 1'b1;
   logic abort_hold = 1'b0;

   assign bin_rdy = rdy_base && !(abort_hold && bvld0 && (bidx0 == 4'd5));

   hist_readout #(.DSIZE(DS), .RAM_RD_LAT(1), .SETTLE_CYC(12), .SKIP_ZERO(0)) u_dut0 (
      .clock(clock), .rst_n(rst_n), .start(start), .finish(finish),
      .get_summary(gs0), .index(ix0), .summary(sum0),
      .bin_idx(bidx0), .bin_cnt(bcnt0), .bin_vld(bvld0), .bin_rdy(bin_rdy), .bin_last(blast0),
      .busy(bsy0), .done(dn0), .total(tot0), .max_cnt(mx0), .max_idx(mi0), .nz_bins(nz0)
   );

   hist_readout #(.DSIZE(DS), .RAM_RD_LAT(1), .SETTLE_CYC(12), .SKIP_ZERO(1)) u_dut1 (
      .clock(clock), .rst_n(rst_n), .start(start), .finish(finish),
      .get_summary(gs1), .index(ix1), .summary(sum1),
      .bin_idx(bidx1), .bin_cnt(bcnt1), .bin_vld(bvld1), .bin_rdy(bin_rdy), .bin_last(blast1),
      .busy(bsy1), .done(dn1), .total(tot1), .max_cnt(mx1), .max_idx(mi1), .nz_bins(nz1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Accumulator read port model: one cycle from index to summary.
   always @(posedge clock) begin
      sum0 <= mem[ix0];
      sum1 <= mem[ix1];
   end

   // Ready pattern: 0 = always, 1 = one cycle in three, 2 = never.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         rdy_ph   = (rdy_ph == 2) ? 0 : rdy_ph + 1;
         rdy_base = (rdy_mode == 0) || ((rdy_mode == 1) && (rdy_ph == 0));
      end
   end

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, d, act, exp);
      end
   endtask

   // Monitor: stream stability, beat scoreboard and done pulses for both instances.
   always @(negedge clock) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            logic  v;
            logic  dn;
            beat_t cur;
            beat_t e;
            v   = (d == 0) ? bvld0 : bvld1;
            dn  = (d == 0) ? dn0 : dn1;
            cur.idx  = (d == 0) ? bidx0 : bidx1;
            cur.cnt  = (d == 0) ? bcnt0 : bcnt1;
            cur.last = (d == 0) ? blast0 : blast1;
            if (held[d] && v) begin
               chk("hold_stable", d, 64'(cur), 64'(held_b[d]));
            end
            if (v && bin_rdy) begin
               if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL beat_unexpected dut%0d: got idx %0d cnt 0x%0h, want no beat",
                           d, cur.idx, cur.cnt);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk("beat_idx", d, 64'(cur.idx), 64'(e.idx));
                  chk("beat_cnt", d, 64'(cur.cnt), 64'(e.cnt));
                  chk("beat_last", d, 64'(cur.last), 64'(e.last));
               end
            end
            held[d]   = v && !bin_rdy;
            held_b[d] = cur;
            if (dn) begin
               chk("done_width", d, 64'(prev_dn[d]), 64'd0);
               if (!prev_dn[d]) begin
                  done_cnt[d]++;
                  done_cyc[d] = cyc;
               end
            end
            prev_dn[d] = dn;
         end
      end
   end

   task automatic push_beats(input int upto);
      beat_t b;
      for (int i = 0; i < upto; i++) begin
         b.idx  = DS'(i);
         b.cnt  = mem[i];
         b.last = (i == NB - 1);
         q0.push_back(b);
         if ((mem[i] != 0) || (i == NB - 1)) q1.push_back(b);
      end
   endtask

   task automatic pulse(input int which);
      @(posedge clock);
      #1;
      if (which == 0) finish = 1'b1;
      else            start  = 1'b1;
      @(posedge clock);
      #1;
      finish  = 1'b0;
      start   = 1'b0;
      fin_cyc = cyc;
   endtask

   task automatic wait_done(input int target, input string name);
      int i;
      i = 0;
      while (!((done_cnt[0] >= target) && (done_cnt[1] >= target)) && (i < 3000)) begin
         @(negedge clock);
         i++;
      end
      chk(name, 0, 64'((done_cnt[0] >= target) && (done_cnt[1] >= target)), 64'd1);
      @(negedge clock);
      @(negedge clock);
      chk("queue_drained", 0, 64'(q0.size()), 64'd0);
      chk("queue_drained", 1, 64'(q1.size()), 64'd0);
   endtask

   task automatic check_stats(input string name, input logic [35:0] t, input logic [31:0] m,
                              input logic [3:0] mi, input logic [4:0] nz);
      chk({name, "_total"}, 0, 64'(tot0), 64'(t));
      chk({name, "_total"}, 1, 64'(tot1), 64'(t));
      chk({name, "_max_cnt"}, 0, 64'(mx0), 64'(m));
      chk({name, "_max_cnt"}, 1, 64'(mx1), 64'(m));
      chk({name, "_max_idx"}, 0, 64'(mi0), 64'(mi));
      chk({name, "_max_idx"}, 1, 64'(mi1), 64'(mi));
      chk({name, "_nz_bins"}, 0, 64'(nz0), 64'(nz));
      chk({name, "_nz_bins"}, 1, 64'(nz1), 64'(nz));
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      finish = 1'b0;
      for (int d = 0; d < 2; d++) begin
         done_cnt[d] = 0;
         done_cyc[d] = 0;
         prev_dn[d]  = 1'b0;
         held[d]     = 1'b0;
      end
      for (int i = 0; i < NB; i++) mem[i] = 32'd0;
      repeat (3) @(posedge clock);
      #1 rst_n = 1'b1;
      @(negedge clock);

      // Reset state
      chk("rst_busy", 0, 64'(bsy0), 64'd0);
      chk("rst_busy", 1, 64'(bsy1), 64'd0);
      chk("rst_vld", 0, 64'(bvld0), 64'd0);
      chk("rst_get_summary", 0, 64'(gs0), 64'd0);
      chk("rst_done", 0, 64'(dn0), 64'd0);
      chk("rst_index", 0, 64'(ix0), 64'd0);
      check_stats("rst", 36'd0, 32'd0, 4'd0, 5'd0);

      // Frame A: bins 3=5, 9=2, ready always high
      mem[3] = 32'd5;
      mem[9] = 32'd2;
      rdy_mode = 0;
      push_beats(NB);
      pulse(0);
      @(negedge clock);
      chk("busy_after_finish", 0, 64'(bsy0), 64'd1);
      wait_done(1, "frameA_done");
      chk("frameA_latency", 0, 64'(done_cyc[0] - fin_cyc), 64'd60);
      chk("frameA_latency", 1, 64'(done_cyc[1] - fin_cyc), 64'd47);
      check_stats("frameA", 36'd7, 32'd5, 4'd3, 5'd2);

      // Tie on equal maxima, ready one cycle in three
      for (int i = 0; i < NB; i++) mem[i] = 32'd0;
      mem[2] = 32'd8;
      mem[7] = 32'd8;
      rdy_mode = 1;
      push_beats(NB);
      pulse(0);
      wait_done(2, "tie_done");
      check_stats("tie", 36'd16, 32'd8, 4'd2, 5'd2);

      // Abort with start while bin 5 is presented
      for (int i = 0; i < NB; i++) mem[i] = 32'(i + 1);
      rdy_mode   = 0;
      abort_hold = 1'b1;
      push_beats(5);
      pulse(0);
      begin
         int i;
         i = 0;
         while (!(bvld0 && (bidx0 == 4'd5)) && (i < 500)) begin
            @(negedge clock);
            i++;
         end
         chk("abort_reached_bin5", 0, 64'(bvld0 && (bidx0 == 4'd5)), 64'd1);
         chk("abort_reached_bin5", 1, 64'(bvld1 && (bidx1 == 4'd5)), 64'd1);
      end
      pulse(1);
      @(negedge clock);
      chk("abort_vld", 0, 64'(bvld0), 64'd0);
      chk("abort_vld", 1, 64'(bvld1), 64'd0);
      chk("abort_get_summary", 0, 64'(gs0), 64'd0);
      chk("abort_get_summary", 1, 64'(gs1), 64'd0);
      chk("abort_busy", 0, 64'(bsy0), 64'd0);
      chk("abort_busy", 1, 64'(bsy1), 64'd0);
      abort_hold = 1'b0;
      repeat (6) @(negedge clock);
      chk("abort_no_done", 0, 64'(done_cnt[0]), 64'd2);
      chk("abort_no_done", 1, 64'(done_cnt[1]), 64'd2);
      chk("abort_queue", 0, 64'(q0.size()), 64'd0);
      chk("abort_queue", 1, 64'(q1.size()), 64'd0);
      check_stats("abort", 36'd21, 32'd6, 4'd5, 5'd6);

      // Rescan from bin 0 after the abort
      push_beats(NB);
      pulse(0);
      wait_done(3, "rescan_done");
      check_stats("rescan", 36'd136, 32'd16, 4'd15, 5'd16);

      // All bins at full scale
      for (int i = 0; i < NB; i++) mem[i] = 32'hFFFF_FFFF;
      push_beats(NB);
      pulse(0);
      wait_done(4, "full_done");
      check_stats("full", 36'hF_FFFF_FFF0, 32'hFFFF_FFFF, 4'd0, 5'd16);

      // Asynchronous reset in the middle of a scan
      rdy_mode = 2;
      pulse(0);
      repeat (20) @(negedge clock);
      chk("pre_reset_busy", 0, 64'(bsy0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 0, 64'(bsy0), 64'd0);
      chk("async_rst_busy", 1, 64'(bsy1), 64'd0);
      chk("async_rst_get_summary", 0, 64'(gs0), 64'd0);
      chk("async_rst_vld", 0, 64'(bvld0), 64'd0);
      chk("async_rst_total", 0, 64'(tot0), 64'd0);
      chk("async_rst_index", 0, 64'(ix0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
